// File: rtl/fetch_pkg.sv
// Shared fetch-side types: the {pc, instr} payload carried from fetch to decode.
package fetch_pkg;

  typedef logic [31:0] T;

  typedef struct packed {
    T pc;
    T instr;
  } fetch_entry_t;

  localparam int unsigned IBUF_DEPTH = 4;

endpackage

// File: rtl/instr_buffer_ram.sv
// Entry storage for instr_buffer: one synchronous write port, one async read port.
module instr_buffer_ram
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  fetch_entry_t          wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output fetch_entry_t          rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // Reset clears the array; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_buffer.sv
// Fetch-to-decode decoupling queue with show-ahead head, count-based full/empty and flush.
module instr_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  T                           instr_from_fetch,
  input  T                           pc_from_fetch,
  input  logic                       valid_from_fetch,
  output logic                       ready_to_fetch,
  output T                           instr_to_decode,
  output T                           pc_to_decode,
  output logic                       valid_to_decode,
  input  logic                       ready_from_decode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_c, pop_c;
  fetch_entry_t  wr_entry_c, rd_entry_c;

  // Handshakes depend only on registered occupancy, so no ready/valid feed-through.
  assign ready_to_fetch  = (count_q != CW'(DEPTH));
  assign valid_to_decode = (count_q != '0);
  assign push_c          = valid_from_fetch && ready_to_fetch;
  assign pop_c           = valid_to_decode && ready_from_decode;

  assign wr_entry_c = '{pc: pc_from_fetch, instr: instr_from_fetch};

  instr_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_c && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry_c)
  );

  // Pointer/count next state; flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count           = count_q;
  assign instr_to_decode = valid_to_decode ? rd_entry_c.instr : '0;
  assign pc_to_decode    = valid_to_decode ? rd_entry_c.pc    : '0;

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: directed stimulus queues expected entries, a monitor checks pops.
module tb_instr_buffer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  T            instr_from_fetch;
  T            pc_from_fetch;
  logic        valid_from_fetch;
  logic        ready_to_fetch;
  T            instr_to_decode;
  T            pc_to_decode;
  logic        valid_to_decode;
  logic        ready_from_decode;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  instr_buffer #(.DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .instr_from_fetch  (instr_from_fetch),
    .pc_from_fetch     (pc_from_fetch),
    .valid_from_fetch  (valid_from_fetch),
    .ready_to_fetch    (ready_to_fetch),
    .instr_to_decode   (instr_to_decode),
    .pc_to_decode      (pc_to_decode),
    .valid_to_decode   (valid_to_decode),
    .ready_from_decode (ready_from_decode)
    ,.count            (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry for a single cycle and record it as expected (caller knows it is accepted).
  task automatic push_one(input T pc, input T instr);
    valid_from_fetch = 1'b1;
    pc_from_fetch    = pc;
    instr_from_fetch = instr;
    exp_q.push_back('{pc: pc, instr: instr});
    tick();
    valid_from_fetch = 1'b0;
  endtask

  task automatic drain(input int n);
    ready_from_decode = 1'b1;
    repeat (n) tick();
    ready_from_decode = 1'b0;
  endtask

  // Monitor: every pop the DUT performs must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && !flush && valid_to_decode && ready_from_decode) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", pc_to_decode, 32'hDEADBEEF);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          chk("pop_pc", pc_to_decode, e.pc);
          chk("pop_instr", instr_to_decode, e.instr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    valid_from_fetch = 1'b0;
    ready_from_decode = 1'b0;
    pc_from_fetch = '0;
    instr_from_fetch = '0;
    #12;
    chk("rst_valid", 32'(valid_to_decode), 32'd0);
    chk("rst_ready", 32'(ready_to_fetch), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", pc_to_decode, 32'd0);
    chk("rst_instr", instr_to_decode, 32'd0);
    reset = 1'b0;
    tick();

    // Single push with decode stalled: visible one cycle later.
    push_one(32'h0, 32'h00000013);
    chk("single_valid", 32'(valid_to_decode), 32'd1);
    chk("single_pc", pc_to_decode, 32'h0);
    chk("single_count", 32'(count), 32'd1);
    drain(1);
    chk("single_empty", 32'(count), 32'd0);

    // Fill to DEPTH, fifth offer must be refused.
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'h00100093 + 32'(i));
    chk("full_ready", 32'(ready_to_fetch), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    valid_from_fetch = 1'b1;
    pc_from_fetch    = 32'h10;
    instr_from_fetch = 32'hBAD00000;
    tick();
    valid_from_fetch = 1'b0;
    chk("full_reject_count", 32'(count), 32'd4);
    drain(4);
    chk("full_drained", 32'(count), 32'd0);
    chk("full_drained_valid", 32'(valid_to_decode), 32'd0);

    // Streaming: one push and one pop per cycle, count stays at 1.
    ready_from_decode = 1'b1;
    valid_from_fetch  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc_from_fetch    = 32'(4 * i);
      instr_from_fetch = 32'h00200013 + 32'(i);
      exp_q.push_back('{pc: pc_from_fetch, instr: instr_from_fetch});
      tick();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_valid", 32'(valid_to_decode), 32'd1);
    end
    valid_from_fetch = 1'b0;
    tick();
    ready_from_decode = 1'b0;
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush at count=3 together with a push and a pop.
    for (int i = 0; i < 3; i++) push_one(32'h200 + 32'(4 * i), 32'h00300013 + 32'(i));
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    valid_from_fetch = 1'b1;
    pc_from_fetch = 32'h20C;
    instr_from_fetch = 32'hBAD00001;
    ready_from_decode = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    valid_from_fetch = 1'b0;
    ready_from_decode = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(valid_to_decode), 32'd0);
    chk("flush_ready", 32'(ready_to_fetch), 32'd1);
    push_one(32'h100, 32'h00400013);
    chk("post_flush_head", pc_to_decode, 32'h100);
    drain(1);

    // Full queue: pop while fetch offers, push lands the next cycle.
    for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(4 * i), 32'h00500013 + 32'(i));
    valid_from_fetch = 1'b1;
    pc_from_fetch = 32'h310;
    instr_from_fetch = 32'h00500017;
    ready_from_decode = 1'b1;
    tick();
    ready_from_decode = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(ready_to_fetch), 32'd1);
    exp_q.push_back('{pc: 32'h310, instr: 32'h00500017});
    tick();
    valid_from_fetch = 1'b0;
    chk("full_refill_count", 32'(count), 32'd4);
    drain(4);
    chk("full_refill_drained", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle with two entries queued.
    push_one(32'h500, 32'h00600013);
    push_one(32'h504, 32'h00600014);
    chk("pre_reset_count", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_valid", 32'(valid_to_decode), 32'd0);
    chk("async_ready", 32'(ready_to_fetch), 32'd1);
    chk("async_count", 32'(count), 32'd0);
    chk("async_pc", pc_to_decode, 32'd0);
    chk("async_instr", instr_to_decode, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Pointer wrap: 2*DEPTH entries through the queue, in pairs.
    for (int i = 0; i < 4; i++) begin
      push_one(32'h400 + 32'(8 * i), 32'h00700013 + 32'(2 * i));
      push_one(32'h404 + 32'(8 * i), 32'h00700014 + 32'(2 * i));
      chk("wrap_count", 32'(count), 32'd2);
      drain(2);
    end
    chk("wrap_empty", 32'(count), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Decoupling queue between the fetch stage and decode. Accepts {instr, pc} pairs from fetch over a valid/ready handshake and presents them in order to decode over a second valid/ready handshake. Discards all buffered entries on a branch redirect (`flush`). Absorbs decode back-pressure so fetch keeps streaming until the queue fills.

## Interface
- `T`, `logic [31:0]`: instruction and PC word type.
- `DEPTH`, 4: number of entries; must be a power of two and ≥ 2.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `flush` input 1: branch redirect; connected to the same `take_branch` that fetch sees.
- `instr_from_fetch` input T: instruction word offered by fetch.
- `pc_from_fetch` input T: PC of that instruction.
- `valid_from_fetch` input 1: fetch offers an entry.
- `ready_to_fetch` output 1: buffer can accept an entry this cycle.
- `instr_to_decode` output T: head instruction.
- `pc_to_decode` output T: head PC.
- `valid_to_decode` output 1: head entry is valid.
- `ready_from_decode` input 1: decode consumes the head this cycle.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Push fires when `valid_from_fetch && ready_to_fetch`; writes {pc, instr} at `wr_ptr` and advances `wr_ptr`.
- Pop fires when `valid_to_decode && ready_from_decode`; advances `rd_ptr`.
- Both pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Occupancy is held in a separate `count` register; there is no pointer-compare full/empty.
- `ready_to_fetch = (count != DEPTH)`. It depends only on registered state, never combinationally on `ready_from_decode`.
- `valid_to_decode = (count != 0)`.
- Data outputs show the head entry (show-ahead) when `count != 0`, and are 0 when empty.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Full: no push, even if decode pops in the same cycle. The slot is accepted on the next cycle.
- Empty: no pop. There is no bypass; a pushed entry is not visible to decode in the cycle it is pushed.
- Flush (synchronous):
  - Highest priority. Sets `count`, `wr_ptr`, `rd_ptr` to 0.
  - Any same-cycle push or pop is ignored.
  - Storage contents are not cleared.
- Reset (asynchronous):
  - Same effect as flush, applied immediately, including mid-transfer.
  - Storage array is also cleared to 0.
  - Outputs after reset: `valid_to_decode`=0, `ready_to_fetch`=1, `count`=0, `instr_to_decode`=0, `pc_to_decode`=0.
- Order preservation: entries leave in push order; none duplicated, none dropped except by flush or reset.

## Timing
- Push-to-visible latency is 1 cycle. An entry pushed at edge N drives `valid_to_decode`=1 after edge N.
- Steady state throughput: 1 push and 1 pop per cycle with `count` constant.
- `ready_to_fetch` falls the cycle after the DEPTH-th outstanding push. It rises the cycle after the first pop from full.
- A flush asserted at edge N gives `valid_to_decode`=0 and `ready_to_fetch`=1 after edge N.
  - Fetch's own post-branch invalid cycle needs no special handling.
  - Entries fetch offers after the flush edge are accepted normally.
- No combinational path from `ready_from_decode` to `ready_to_fetch`.
- No combinational path from `valid_from_fetch` to `valid_to_decode`.

## Structure
- Shared package `fetch_pkg`:
  - `typedef struct packed { T pc; T instr; } fetch_entry_t`.
  - `localparam IBUF_DEPTH = 4`.
- Storage is an array of `fetch_entry_t`, written with the push condition and read at `rd_ptr`.
- Optional sub-module `instr_buffer_ram` (1 write port, 1 async read port, DEPTH entries). Inline storage is acceptable.
- Pointer and count control stay in `instr_buffer`.

## Test plan
- Reset, then push pc 0x0 instr 0x00000013 with decode ready=0:
  - Next cycle: `valid_to_decode`=1, `pc_to_decode`=0x0, `count`=1.
- Push 4 entries (pc 0x0–0xC) with decode stalled:
  - `ready_to_fetch`=0 after the 4th push; a 5th offer is not accepted.
  - Release decode → pops 0x0, 0x4, 0x8, 0xC in order.
- Streaming: fetch valid=1 and decode ready=1 for 20 cycles:
  - `count` stays 1 after the first cycle; PCs 0x0..0x4C emerge in order with no gaps.
- At count=3, assert flush together with a push and a pop:
  - Next cycle: `count`=0, `valid_to_decode`=0, `ready_to_fetch`=1.
  - Next push at pc 0x100 emerges as the first entry.
- Full queue, decode pops while fetch offers:
  - That cycle: no push, `count` goes to 3.
  - Following cycle: push accepted, `count` returns to 4.
- Async reset asserted mid-cycle with count=2:
  - Outputs go to reset values without waiting for a clock edge.
  - Pointer wrap verified after 2·DEPTH pushes and pops.
